// File: rtl/hs_cdc_pulse_pacer.sv
// -----------------------------------------------------------------------------
// hs_cdc_pulse_pacer
//
// Purpose:
//   Accepts single-cycle event requests, queues them in a saturating pending
//   counter and replays them as single-cycle pulses with at least GAP_CYCLES
//   idle cycles between pulses. The paced output feeds a pulse synchroniser's
//   pulse_in, which needs spacing so that every pulse survives the crossing.
//
// Parameters:
//   ACTIVE_LEVEL : LEVEL_HIGH / LEVEL_LOW, active level of pulse_out
//   GAP_CYCLES   : 1..255, idle cycles forced between consecutive pulses
//   CNT_WIDTH    : 1..16, width of the pending-event counter
//
// Ports:
//   clk          in   rising-edge clock for all logic
//   srst         in   synchronous active-high reset
//   evt_valid    in   event request
//   evt_ready    out  pacer can accept an event (combinational)
//   flush        in   discard all pending events
//   pulse_out    out  paced single-cycle pulse (registered)
//   pending_cnt  out  events accepted but not yet emitted
//   busy         out  FSM not idle or events still pending
//   sent_cnt     out  16-bit wrapping count of emitted pulses
//                     (only when HS_CDC_PULSE_PACER_STAT_EN is defined)
//
// Configuration macro:
//   HS_CDC_PULSE_PACER_STAT_EN - adds the sent_cnt statistics output.
// -----------------------------------------------------------------------------

package hs_cdc_pulse_pacer_pkg;

    typedef enum logic {
        LEVEL_LOW  = 1'b0,
        LEVEL_HIGH = 1'b1
    } level_e;

endpackage : hs_cdc_pulse_pacer_pkg

module hs_cdc_pulse_pacer
    import hs_cdc_pulse_pacer_pkg::*;
#(
    parameter level_e ACTIVE_LEVEL = LEVEL_HIGH,
    parameter int     GAP_CYCLES   = 6,
    parameter int     CNT_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 evt_valid,
    output logic                 evt_ready,
    input  logic                 flush,
    output logic                 pulse_out,
    output logic [CNT_WIDTH-1:0] pending_cnt,
    output logic                 busy
`ifdef HS_CDC_PULSE_PACER_STAT_EN
    ,
    output logic [15:0]          sent_cnt
`endif
);

    localparam logic [CNT_WIDTH-1:0] PEND_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] PEND_ONE  = CNT_WIDTH'(1);
    localparam logic [7:0]           GAP_LOAD  = 8'(GAP_CYCLES);
    localparam logic                 LVL_ACT   = logic'(ACTIVE_LEVEL);
    localparam logic                 LVL_INACT = ~logic'(ACTIVE_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             gap_q,   gap_d;
    logic [CNT_WIDTH-1:0]   pend_q,  pend_d;
    logic                   pulse_q, pulse_d;

    logic                   accept;
    logic                   emit_dec;

    // Ready drops when the counter is saturated, and also under flush since
    // flush discards whatever would be accepted on that edge anyway.
    assign evt_ready = (pend_q != PEND_MAX) && !flush;
    assign accept    = evt_valid && evt_ready;
    // The guard on pend_q keeps the counter from underflowing even if an
    // EMIT cycle ever finds the count already at zero.
    assign emit_dec  = (state_q == ST_EMIT) && (pend_q != '0);

    // Pending counter: flush wins, an accept and a decrement on the same
    // edge cancel out, and saturation is prevented by evt_ready.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else if (accept && !emit_dec) begin
            pend_d = pend_q + PEND_ONE;
        end else if (!accept && emit_dec) begin
            pend_d = pend_q - PEND_ONE;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pulse_d = LVL_INACT;

        unique case (state_q)
            ST_IDLE: begin
                // A flush on this edge discards the event that would have
                // started the pulse, so no pulse is emitted for it.
                if ((pend_q != '0) && !flush) begin
                    state_d = ST_EMIT;
                end
            end

            ST_EMIT: begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
            end

            ST_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    gap_d = '0;
                    // Looks at the count after this edge's update so that a
                    // back-to-back stream keeps the GAP_CYCLES+1 period.
                    state_d = (pend_d != '0) ? ST_EMIT : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gap_d   = '0;
            end
        endcase

        // pulse_out is registered, so it is driven from the next state.
        if (state_d == ST_EMIT) begin
            pulse_d = LVL_ACT;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (srst) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            pend_q  <= '0;
            pulse_q <= LVL_INACT;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out   = pulse_q;
    assign pending_cnt = pend_q;
    assign busy        = (state_q != ST_IDLE) || (pend_q != '0);

`ifdef HS_CDC_PULSE_PACER_STAT_EN
    logic [15:0] sent_q, sent_d;

    // Counts EMIT cycles; wraps naturally at 16 bits and ignores flush.
    always_comb begin
        sent_d = sent_q;
        if (state_q == ST_EMIT) begin
            sent_d = sent_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

    assign sent_cnt = sent_q;
`endif

endmodule : hs_cdc_pulse_pacer

// File: tb/tb_hs_cdc_pulse_pacer.sv
// -----------------------------------------------------------------------------
// tb_hs_cdc_pulse_pacer
//
// Two pacers share clock and reset:
//   dut A : LEVEL_HIGH, GAP_CYCLES=6, CNT_WIDTH=4
//   dut B : LEVEL_LOW,  GAP_CYCLES=3, CNT_WIDTH=2
// A timeline model (pending count plus time of the last pulse) predicts every
// output each cycle; directed sequences add hand-computed expectations.
// -----------------------------------------------------------------------------

module tb_hs_cdc_pulse_pacer;
    import hs_cdc_pulse_pacer_pkg::*;

    localparam int A_G   = 6;
    localparam int A_W   = 4;
    localparam int A_MAX = 15;
    localparam int B_G   = 3;
    localparam int B_W   = 2;
    localparam int B_MAX = 3;

    logic clk = 1'b0;
    logic srst;
    logic a_valid, a_flush, b_valid, b_flush;

    logic             a_ready, a_pulse, a_busy;
    logic [A_W-1:0]   a_pend;
    logic             b_ready, b_pulse, b_busy;
    logic [B_W-1:0]   b_pend;
`ifdef HS_CDC_PULSE_PACER_STAT_EN
    logic [15:0]      a_sent, b_sent;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hs_cdc_pulse_pacer #(
        .ACTIVE_LEVEL (LEVEL_HIGH),
        .GAP_CYCLES   (A_G),
        .CNT_WIDTH    (A_W)
    ) u_dut_a (
        .clk         (clk),
        .srst        (srst),
        .evt_valid   (a_valid),
        .evt_ready   (a_ready),
        .flush       (a_flush),
        .pulse_out   (a_pulse),
        .pending_cnt (a_pend),
        .busy        (a_busy)
`ifdef HS_CDC_PULSE_PACER_STAT_EN
        ,
        .sent_cnt    (a_sent)
`endif
    );

    hs_cdc_pulse_pacer #(
        .ACTIVE_LEVEL (LEVEL_LOW),
        .GAP_CYCLES   (B_G),
        .CNT_WIDTH    (B_W)
    ) u_dut_b (
        .clk         (clk),
        .srst        (srst),
        .evt_valid   (b_valid),
        .evt_ready   (b_ready),
        .flush       (b_flush),
        .pulse_out   (b_pulse),
        .pending_cnt (b_pend),
        .busy        (b_busy)
`ifdef HS_CDC_PULSE_PACER_STAT_EN
        ,
        .sent_cnt    (b_sent)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge, then settle; inputs are changed only after this.
    task automatic cyc_step();
        @(posedge clk);
        #2;
    endtask

    // ---------------------------------------------------------------------
    // Timeline model. p is the pending count during the current cycle,
    // last is the cycle index of the most recent pulse and pulse says
    // whether the current cycle carries a pulse. A pulse may start exactly
    // at last+g+1 if anything is pending after that edge, or any later
    // cycle if something was pending before the edge and no flush hit.
    // ---------------------------------------------------------------------
    function automatic void model_step(input int g, input int maxc,
                                       input logic rst, input logic valid,
                                       input logic fl, input int c,
                                       inout int p, inout int last,
                                       inout bit pulse);
        int p_new;
        bit acc;
        bit nxt;
        if (rst) begin
            p     = 0;
            last  = -1000;
            pulse = 1'b0;
            return;
        end
        acc   = valid && (p != maxc) && !fl;
        p_new = fl ? 0 : p + (acc ? 1 : 0) - (pulse ? 1 : 0);
        if (c == last + g + 1)     nxt = (p_new > 0);
        else if (c > last + g + 1) nxt = (p > 0) && !fl;
        else                       nxt = 1'b0;
        if (nxt) last = c;
        p     = p_new;
        pulse = nxt;
    endfunction

    int cyc      = 0;
    bit m_ok     = 1'b0;
    int ma_p     = 0, mb_p = 0;
    int ma_last  = -1000, mb_last = -1000;
    bit ma_pulse = 1'b0, mb_pulse = 1'b0;
`ifdef HS_CDC_PULSE_PACER_STAT_EN
    int ma_sent  = 0, mb_sent = 0;
`endif

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
`ifdef HS_CDC_PULSE_PACER_STAT_EN
            if (srst) begin
                ma_sent = 0;
                mb_sent = 0;
            end else begin
                if (ma_pulse) ma_sent = (ma_sent + 1) % 65536;
                if (mb_pulse) mb_sent = (mb_sent + 1) % 65536;
            end
`endif
            model_step(A_G, A_MAX, srst, a_valid, a_flush, cyc, ma_p, ma_last, ma_pulse);
            model_step(B_G, B_MAX, srst, b_valid, b_flush, cyc, mb_p, mb_last, mb_pulse);
            if (srst) m_ok = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Per-cycle compare, plus pulse counting and spacing on the DUT side.
    // ---------------------------------------------------------------------
    int a_pulses = 0, b_pulses = 0;
    int a_seen   = -1000, b_seen = -1000;
    int a_times[$];

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                check("a_pulse", 32'(a_pulse), 32'(ma_pulse));
                check("a_pend",  32'(a_pend),  32'(ma_p));
                check("a_busy",  32'(a_busy),  32'((cyc - ma_last <= A_G) || (ma_p != 0)));
                check("a_ready", 32'(a_ready), 32'((ma_p != A_MAX) && !a_flush));
                check("b_pulse", 32'(b_pulse), 32'(!mb_pulse));
                check("b_pend",  32'(b_pend),  32'(mb_p));
                check("b_busy",  32'(b_busy),  32'((cyc - mb_last <= B_G) || (mb_p != 0)));
                check("b_ready", 32'(b_ready), 32'((mb_p != B_MAX) && !b_flush));
`ifdef HS_CDC_PULSE_PACER_STAT_EN
                check("a_sent", 32'(a_sent), 32'(ma_sent));
                check("b_sent", 32'(b_sent), 32'(mb_sent));
`endif
                if (a_pulse === 1'b1) begin
                    check("a_spacing", 32'(cyc - a_seen >= A_G + 1), 32'd1);
                    a_seen = cyc;
                    a_pulses++;
                    a_times.push_back(cyc);
                end
                if (b_pulse === 1'b0) begin
                    check("b_spacing", 32'(cyc - b_seen >= B_G + 1), 32'd1);
                    b_seen = cyc;
                    b_pulses++;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations.
    // ---------------------------------------------------------------------
    int exp_a_burst[5] = '{1, 2, 2, 3, 4};
    int exp_b_full[6]  = '{1, 2, 2, 3, 3, 3};

    initial begin
        int base;
        int peak;

        srst    = 1'b1;
        a_valid = 1'b0;
        a_flush = 1'b0;
        b_valid = 1'b0;
        b_flush = 1'b0;

        // Reset state.
        repeat (2) cyc_step();
        check("rst_a_pulse", 32'(a_pulse), 32'd0);
        check("rst_a_pend",  32'(a_pend),  32'd0);
        check("rst_a_busy",  32'(a_busy),  32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_b_pulse", 32'(b_pulse), 32'd1);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        check("rst_b_busy",  32'(b_busy),  32'd0);
        srst = 1'b0;
        cyc_step();

        // Single event: pulse on the second edge after the accept.
        a_valid = 1'b1;
        cyc_step();
        a_valid = 1'b0;
        check("single_pend_k",   32'(a_pend),  32'd1);
        check("single_pulse_k",  32'(a_pulse), 32'd0);
        cyc_step();
        check("single_pulse_k1", 32'(a_pulse), 32'd1);
        check("single_pend_k1",  32'(a_pend),  32'd1);
        cyc_step();
        check("single_pulse_k2", 32'(a_pulse), 32'd0);
        check("single_pend_k2",  32'(a_pend),  32'd0);
        check("single_busy_k2",  32'(a_busy),  32'd1);
        repeat (A_G - 1) cyc_step();
        check("single_busy_last", 32'(a_busy), 32'd1);
        cyc_step();
        check("single_busy_done", 32'(a_busy), 32'd0);

        // Burst of 5: accept on the EMIT cycle leaves the count unchanged,
        // peak of 4, five pulses with period 7.
        base    = a_pulses;
        peak    = 0;
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc_step();
            check("burst_pend", 32'(a_pend), 32'(exp_a_burst[i]));
            if (int'(a_pend) > peak) peak = int'(a_pend);
        end
        a_valid = 1'b0;
        check("burst_peak", 32'(peak), 32'd4);
        repeat (40) cyc_step();
        check("burst_count", 32'(a_pulses - base), 32'd5);
        if (a_pulses - base == 5) begin
            for (int i = 0; i < 4; i++) begin
                check("burst_period", 32'(a_times[base + i + 1] - a_times[base + i]), 32'd7);
            end
        end

        // Flush in GAP with three pending: count clears, GAP completes,
        // no further pulse.
        base    = a_pulses;
        a_valid = 1'b1;
        repeat (4) cyc_step();
        check("flush_pend_before", 32'(a_pend), 32'd3);
        a_valid = 1'b0;
        a_flush = 1'b1;
        #1;
        check("flush_ready", 32'(a_ready), 32'd0);
        cyc_step();
        a_flush = 1'b0;
        check("flush_pend_after", 32'(a_pend), 32'd0);
        check("flush_busy_gap",   32'(a_busy), 32'd1);
        repeat (3) cyc_step();
        check("flush_busy_end",   32'(a_busy), 32'd1);
        cyc_step();
        check("flush_busy_idle",  32'(a_busy), 32'd0);
        repeat (10) cyc_step();
        check("flush_count", 32'(a_pulses - base), 32'd1);

        // Flush together with a request: flush wins.
        a_valid = 1'b1;
        a_flush = 1'b1;
        cyc_step();
        a_valid = 1'b0;
        a_flush = 1'b0;
        check("flush_accept_pend", 32'(a_pend), 32'd0);
        repeat (3) cyc_step();
        check("flush_accept_busy", 32'(a_busy), 32'd0);

        // Full counter on B (width 2, active low): ready drops at 3,
        // exactly 4 pulses.
        base    = b_pulses;
        b_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc_step();
            check("full_pend", 32'(b_pend), 32'(exp_b_full[i]));
            if (i == 1) check("low_pulse_active", 32'(b_pulse), 32'd0);
            if (i == 2) check("low_pulse_idle",   32'(b_pulse), 32'd1);
            if (i == 3) check("full_ready",       32'(b_ready), 32'd0);
        end
        b_valid = 1'b0;
        repeat (25) cyc_step();
        check("full_count", 32'(b_pulses - base), 32'd4);
        check("full_b_busy", 32'(b_busy), 32'd0);

        // Reset during EMIT: pulse ends at the reset edge, nothing follows.
        base    = a_pulses;
        a_valid = 1'b1;
        cyc_step();
        a_valid = 1'b0;
        cyc_step();
        check("rst_emit_pulse", 32'(a_pulse), 32'd1);
        srst = 1'b1;
        cyc_step();
        srst = 1'b0;
        check("rst_emit_pulse_off", 32'(a_pulse), 32'd0);
        check("rst_emit_pend",      32'(a_pend),  32'd0);
        check("rst_emit_busy",      32'(a_busy),  32'd0);
        repeat (15) cyc_step();
        check("rst_emit_count", 32'(a_pulses - base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_hs_cdc_pulse_pacer
